// File: rtl/dmem_hs.sv
// rtl/dmem_hs.sv - multi-cycle valid/ready data memory with optional subword access (DMEM_SUBWORD_EN)
module dmem_hs #(
  parameter int DEPTH   = 4096,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          write_q, write_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
`ifdef DMEM_SUBWORD_EN
  logic [1:0]    size_q, size_d;
  logic          signed_q, signed_d;
  logic [1:0]    lane_q, lane_d;
`else
  logic          unused_signed;
  assign unused_signed = req_signed;
`endif

  logic [31:0] mem [DEPTH];

  logic        illegal;
  logic        access;
  logic [3:0]  be;
  logic [31:0] wword;
  logic [31:0] rword;
  logic [31:0] load_val;

  assign access     = (state_q == S_WAIT) && (cnt_q == 4'd0);
  assign rword      = mem[idx_q];
  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q == S_WAIT) || (state_q == S_RESP);
  assign resp_valid = (state_q == S_RESP) || (state_q == S_ERR);
  assign err        = (state_q == S_ERR);
  assign rdata      = (state_q == S_RESP) ? rdata_q : 32'd0;

  // Classify the incoming request: range, size and alignment checks.
  always_comb begin
    illegal = ({2'b00, addr[31:2]} >= DEPTH_W);
`ifdef DMEM_SUBWORD_EN
    case (req_size)
      2'd0:    ;
      2'd1:    if (addr[0]) illegal = 1'b1;
      2'd2:    if (addr[1:0] != 2'b00) illegal = 1'b1;
      default: illegal = 1'b1;
    endcase
`else
    if (req_size != 2'd2 || addr[1:0] != 2'b00) illegal = 1'b1;
`endif
  end

  // Lane steering: byte enables and replicated store data, extended load data.
`ifdef DMEM_SUBWORD_EN
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    be       = 4'b0000;
    wword    = wdata_q;
    b        = rword[{lane_q, 3'b000} +: 8];
    h        = lane_q[1] ? rword[31:16] : rword[15:0];
    load_val = rword;
    case (size_q)
      2'd0: begin
        be[lane_q] = 1'b1;
        wword      = {4{wdata_q[7:0]}};
        load_val   = {{24{signed_q & b[7]}}, b};
      end
      2'd1: begin
        be       = lane_q[1] ? 4'b1100 : 4'b0011;
        wword    = {2{wdata_q[15:0]}};
        load_val = {{16{signed_q & h[15]}}, h};
      end
      default: be = 4'b1111;
    endcase
  end
`else
  always_comb begin
    be       = 4'b1111;
    wword    = wdata_q;
    load_val = rword;
  end
`endif

  // Next-state logic: capture on handshake, count wait cycles, perform access.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef DMEM_SUBWORD_EN
    size_d   = size_q;
    signed_d = signed_q;
    lane_d   = lane_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          idx_d   = addr[AW+1:2];
          wdata_d = wdata;
`ifdef DMEM_SUBWORD_EN
          size_d   = req_size;
          signed_d = req_signed;
          lane_d   = addr[1:0];
`endif
          if (illegal) begin
            state_d = S_ERR;
          end else begin
            cnt_d   = 4'(LATENCY);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          rdata_d = write_q ? 32'd0 : load_val;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and request registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
`ifdef DMEM_SUBWORD_EN
      size_q   <= 2'd0;
      signed_q <= 1'b0;
      lane_q   <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef DMEM_SUBWORD_EN
      size_q   <= size_d;
      signed_q <= signed_d;
      lane_q   <= lane_d;
`endif
    end
  end

  // Storage array: not reset; a store in flight is dropped if reset arrives first.
  always_ff @(posedge clk) begin
    if (!reset && access && write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx_q][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_hs.sv
// tb/tb_dmem_hs.sv - scoreboard testbench for dmem_hs
module tb_dmem_hs;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd2;
  logic        req_signed = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        err;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          due;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  dmem_hs #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .addr(addr), .wdata(wdata), .resp_valid(resp_valid), .rdata(rdata),
    .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor: pops the scoreboard on every resp_valid, checks idle outputs otherwise.
  always @(negedge clk) begin
    if (!reset) begin
      if (resp_valid) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_resp: resp_valid with empty scoreboard at cycle %0d", cyc);
        end else begin
          failures = failures;
          mon_e = sb.pop_front();
          if (rdata !== mon_e.data) begin
            failures++;
            $display("FAIL %s rdata: got %h expected %h", mon_e.name, rdata, mon_e.data);
          end
          checks++;
          if (err !== mon_e.err) begin
            failures++;
            $display("FAIL %s err: got %b expected %b", mon_e.name, err, mon_e.err);
          end
          checks++;
          if (cyc !== mon_e.due) begin
            failures++;
            $display("FAIL %s latency: resp at cycle %0d expected %0d", mon_e.name, cyc, mon_e.due);
          end
        end
      end else begin
        checks++;
        if (rdata !== 32'd0 || err !== 1'b0) begin
          failures++;
          $display("FAIL idle_outputs: rdata=%h err=%b expected 0/0 at cycle %0d", rdata, err, cyc);
        end
      end
    end
  end

  // Drive one request (caller at negedge), wait for acceptance, optionally queue the expected response.
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic e_err, input logic [31:0] e_data,
                       input bit push, input string nm, output int hs);
    exp_t e;
    int k;
    req_valid  = 1'b1;
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    addr       = a;
    wdata      = d;
    k = 0;
    while (!req_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    hs = cyc;
    if (k >= 100) begin
      checks++;
      failures++;
      $display("FAIL %s accept_timeout: req_ready=%b expected 1", nm, req_ready);
    end else if (push) begin
      e.err  = e_err;
      e.data = e_data;
      e.due  = cyc + (e_err ? 1 : LAT + 2);
      e.name = nm;
      sb.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 60) begin
      @(posedge clk);
      k++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic sw(input logic [31:0] a, input logic [31:0] d, input string nm);
    int hs;
    issue(1'b1, 2'd2, 1'b0, a, d, 1'b0, 32'd0, 1'b1, nm, hs);
    drain();
  endtask

  task automatic ld(input logic [1:0] sz, input logic sg, input logic [31:0] a,
                    input logic e_err, input logic [31:0] e_data, input string nm);
    int hs;
    issue(1'b0, sz, sg, a, 32'd0, e_err, e_data, 1'b1, nm, hs);
    drain();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || rdata !== 32'd0 || err !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_state: ready=%b resp_valid=%b rdata=%h err=%b busy=%b expected 1 0 0 0 0",
                 req_ready, resp_valid, rdata, err, busy);
      end
    end
  endtask

  task automatic test_word();
    sw(32'h100, 32'hDEADBEEF, "sw_100");
    ld(2'd2, 1'b0, 32'h100, 1'b0, 32'hDEADBEEF, "lw_100");
    sw(32'h0, 32'h12345678, "sw_000");
    ld(2'd2, 1'b1, 32'h0, 1'b0, 32'h12345678, "lw_000_signed_ignored");
  endtask

  task automatic test_subword();
    int hs;
    sw(32'h40, 32'h11223344, "sw_040");
`ifdef DMEM_SUBWORD_EN
    issue(1'b1, 2'd0, 1'b0, 32'h41, 32'hFFFFFFAA, 1'b0, 32'd0, 1'b1, "sb_041", hs);
    drain();
    ld(2'd2, 1'b0, 32'h40, 1'b0, 32'h1122AA44, "lw_after_sb");
    ld(2'd0, 1'b1, 32'h41, 1'b0, 32'hFFFFFFAA, "lb_041");
    ld(2'd0, 1'b0, 32'h41, 1'b0, 32'h000000AA, "lbu_041");
    ld(2'd1, 1'b1, 32'h42, 1'b0, 32'h00001122, "lh_042");
    ld(2'd1, 1'b1, 32'h40, 1'b0, 32'hFFFFAA44, "lh_040");
    ld(2'd1, 1'b0, 32'h40, 1'b0, 32'h0000AA44, "lhu_040");
    issue(1'b1, 2'd1, 1'b0, 32'h42, 32'h0000BEEF, 1'b0, 32'd0, 1'b1, "sh_042", hs);
    drain();
    ld(2'd2, 1'b0, 32'h40, 1'b0, 32'hBEEFAA44, "lw_after_sh");
    ld(2'd1, 1'b0, 32'h41, 1'b1, 32'd0, "lh_misaligned");
`else
    issue(1'b1, 2'd0, 1'b0, 32'h41, 32'hFFFFFFAA, 1'b1, 32'd0, 1'b1, "sb_disabled", hs);
    drain();
    ld(2'd2, 1'b0, 32'h40, 1'b0, 32'h11223344, "lw_after_sb_disabled");
    ld(2'd0, 1'b1, 32'h41, 1'b1, 32'd0, "lb_disabled");
    ld(2'd1, 1'b0, 32'h40, 1'b1, 32'd0, "lh_disabled");
`endif
  endtask

  task automatic test_errors();
    int hs;
    ld(2'd2, 1'b0, 32'h102, 1'b1, 32'd0, "lw_misaligned");
    issue(1'b1, 2'd2, 1'b0, 32'h102, 32'hCAFEF00D, 1'b1, 32'd0, 1'b1, "sw_misaligned", hs);
    drain();
    ld(2'd2, 1'b0, 32'h100, 1'b0, 32'hDEADBEEF, "lw_100_unchanged");
    issue(1'b1, 2'd2, 1'b0, 32'(4*DEPTH), 32'hFFFFFFFF, 1'b1, 32'd0, 1'b1, "sw_out_of_range", hs);
    drain();
    ld(2'd2, 1'b0, 32'(4*DEPTH), 1'b1, 32'd0, "lw_out_of_range");
    ld(2'd2, 1'b0, 32'h0, 1'b0, 32'h12345678, "lw_000_unchanged");
    ld(2'd3, 1'b0, 32'h100, 1'b1, 32'd0, "size3_load");
  endtask

  task automatic test_reset_mid_store();
    int hs;
    int seen;
    sw(32'h200, 32'h0, "sw_200_zero");
    issue(1'b1, 2'd2, 1'b0, 32'h200, 32'h55, 1'b0, 32'd0, 1'b0, "sw_200_aborted", hs);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < LAT + 4; i++) begin
      if (resp_valid !== 1'b0) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL reset_mid_store_resp: resp_valid seen %0d times expected 0", seen);
    end
    ld(2'd2, 1'b0, 32'h200, 1'b0, 32'h0, "lw_200_after_abort");
  endtask

  task automatic test_back_to_back();
    int hs1;
    int hs2;
    sw(32'h300, 32'hA5A50001, "sw_300");
    sw(32'h304, 32'h5A5A0002, "sw_304");
    issue(1'b0, 2'd2, 1'b0, 32'h300, 32'd0, 1'b0, 32'hA5A50001, 1'b1, "lw_300_first", hs1);
    checks++;
    if (req_ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_state: ready=%b busy=%b expected 0 1", req_ready, busy);
    end
    issue(1'b0, 2'd2, 1'b0, 32'h304, 32'd0, 1'b0, 32'h5A5A0002, 1'b1, "lw_304_second", hs2);
    drain();
    checks++;
    if (hs2 - hs1 != LAT + 3) begin
      failures++;
      $display("FAIL throughput: handshake spacing %0d expected %0d", hs2 - hs1, LAT + 3);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_subword();
    test_errors();
    test_reset_mid_store();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
